// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA raster timing: h/v counters, sync decode, pixel request and
// visible-window gating of the picture generator's registered pixel data.
module vga_timing_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 40,
  parameter int H_LEFT   = 8,
  parameter int H_VALID  = 640,
  parameter int H_RIGHT  = 8,
  parameter int H_FRONT  = 8,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 25,
  parameter int V_TOP    = 8,
  parameter int V_VALID  = 480,
  parameter int V_BOTTOM = 8,
  parameter int V_FRONT  = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [11:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int HS      = H_SYNC + H_BACK + H_LEFT;
  localparam int VS      = V_SYNC + V_BACK + V_TOP;
  localparam int HW      = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          frame_wrap;
  logic          row_vis;
  logic          req_p0;
  logic          vld_p1;

  function automatic logic in_span(input int c, input int lo, input int len);
    return (c >= lo) && (c < lo + len);
  endfunction

  assign h_last     = (int'(h_cnt) == H_TOTAL - 1);
  assign v_last     = (int'(v_cnt) == V_TOTAL - 1);
  assign frame_wrap = h_last && v_last;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign hsync = (int'(h_cnt) < H_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vsync = (int'(v_cnt) < V_SYNC) ? SYNC_POL : ~SYNC_POL;

  // Stage p0: request window runs one pixel ahead of the visible window
  assign row_vis = in_span(int'(v_cnt), VS, V_VALID);
  assign req_p0  = row_vis && in_span(int'(h_cnt), HS - 1, H_VALID);
  assign pix_x   = req_p0 ? 10'(int'(h_cnt) - (HS - 1)) : 10'h3FF;
  assign pix_y   = req_p0 ? 10'(int'(v_cnt) - VS) : 10'h3FF;

  // Stage p1: generator has registered the p0 request; gate it onto the pins
  assign vld_p1 = row_vis && in_span(int'(h_cnt), HS, H_VALID);
  assign rgb    = vld_p1 ? pix_data : 12'h000;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size instance for line timing and a
// shrunken instance (inverted sync polarity) for frame-level behaviour.
module tb_vga_timing_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pd_a  = 12'hABC;
  logic [11:0] pd_s  = 12'h000;
  logic [9:0]  px_a, py_a, px_s, py_s;
  logic        hs_a, vs_a, hs_s, vs_s, fs_a, fs_s;
  logic [11:0] rgb_a, rgb_s;
  logic [7:0]  fc_a, fc_s;

  int total = 0;
  int bad   = 0;
  int t_cnt = 0;
  bit phase1 = 1'b1;

  int a_hs_low0 = 0, a_hs_high0 = 0, a_vs_act0 = 0;
  int a_abc = 0, a_first = -1, a_last = -1, a_px0_h = -1, a_px639_h = -1;
  int a_py0 = 0, a_l34_bad = 0;
  int s_fs_cnt = 0, s_fs_t1 = -1, s_fs_t2 = -1, s_vs_act0 = 0;
  int s_fc_255 = -1, s_fc_wrap = -1, s_fs_wrap = -1;

  always #5 clk = ~clk;

  vga_timing_ctrl dut_a (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pd_a),
    .pix_x(px_a), .pix_y(py_a), .hsync(hs_a), .vsync(vs_a),
    .rgb(rgb_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_ctrl #(
    .H_SYNC(3), .H_BACK(2), .H_LEFT(1), .H_VALID(8), .H_RIGHT(1), .H_FRONT(1),
    .V_SYNC(2), .V_BACK(1), .V_TOP(1), .V_VALID(4), .V_BOTTOM(1), .V_FRONT(1),
    .SYNC_POL(1'b1)
  ) dut_s (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pd_s),
    .pix_x(px_s), .pix_y(py_s), .hsync(hs_s), .vsync(vs_s),
    .rgb(rgb_s), .frame_start(fs_s), .frame_cnt(fc_s)
  );

  typedef struct packed {
    int   h;
    int   v;
    logic hs;
    logic vs;
    int   px;
    int   py;
    logic valid;
    int   x;
    int   y;
    logic fs;
    int   fc;
  } exp_t;

  // Expected outputs from the number of clock edges since reset release.
  function automatic exp_t calc(input int t, input int hsw, input int hb, input int hl,
                                input int hv, input int hr, input int hf,
                                input int vsw, input int vb, input int vt, input int vv,
                                input int vbo, input int vf, input logic pol);
    exp_t e;
    int ht, vtot, ft, hs0, vs0;
    bit row, req;
    ht   = hsw + hb + hl + hv + hr + hf;
    vtot = vsw + vb + vt + vv + vbo + vf;
    ft   = ht * vtot;
    hs0  = hsw + hb + hl;
    vs0  = vsw + vb + vt;
    e.h  = t % ht;
    e.v  = (t / ht) % vtot;
    e.hs = (e.h < hsw) ? pol : ~pol;
    e.vs = (e.v < vsw) ? pol : ~pol;
    row  = (e.v >= vs0) && (e.v < vs0 + vv);
    req  = row && (e.h >= hs0 - 1) && (e.h < hs0 + hv - 1);
    e.valid = row && (e.h >= hs0) && (e.h < hs0 + hv);
    e.px = req ? e.h - (hs0 - 1) : 'h3FF;
    e.py = req ? e.v - vs0 : 'h3FF;
    e.x  = e.h - hs0;
    e.y  = e.v - vs0;
    e.fs = (t > 0) && (t % ft == 0);
    e.fc = (t / ft) % 256;
    return e;
  endfunction

  function automatic logic [11:0] gen_f(input int x, input int y);
    return 12'((x * 37 + y * 113 + 5) & 'hFFF);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", nm, t_cnt, act, exp);
    end
  endtask

  // Edge count since reset release drives the model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_cnt <= 0;
    else        t_cnt <= t_cnt + 1;
  end

  // Picture generator stand-in for the small instance: one register stage.
  always @(posedge clk) pd_s <= gen_f(int'(px_s), int'(py_s));

  always @(negedge clk) begin
    exp_t ea;
    exp_t es;
    int   h;
    ea = calc(t_cnt, 96, 40, 8, 640, 8, 8, 2, 25, 8, 480, 8, 2, 1'b0);
    es = calc(t_cnt, 3, 2, 1, 8, 1, 1, 2, 1, 1, 4, 1, 1, 1'b1);
    chk("a_hsync", hs_a, ea.hs);
    chk("a_vsync", vs_a, ea.vs);
    chk("a_pix_x", px_a, ea.px);
    chk("a_pix_y", py_a, ea.py);
    chk("a_rgb", rgb_a, ea.valid ? 12'hABC : 12'h000);
    chk("a_frame_start", fs_a, ea.fs);
    chk("a_frame_cnt", fc_a, ea.fc);
    chk("s_hsync", hs_s, es.hs);
    chk("s_vsync", vs_s, es.vs);
    chk("s_pix_x", px_s, es.px);
    chk("s_pix_y", py_s, es.py);
    chk("s_rgb", rgb_s, es.valid ? gen_f(es.x, es.y) : 12'h000);
    chk("s_frame_start", fs_s, es.fs);
    chk("s_frame_cnt", fc_s, es.fc);
    if (phase1 && rst_n) begin
      h = t_cnt % 800;
      if (t_cnt < 800) begin
        if (hs_a == 1'b0) a_hs_low0++;
        else              a_hs_high0++;
      end
      if (t_cnt < 1600 && vs_a == 1'b0) a_vs_act0++;
      if (t_cnt / 800 == 35) begin
        if (rgb_a == 12'hABC) begin
          a_abc++;
          if (a_first < 0) a_first = h;
          a_last = h;
        end
        if (px_a == 10'd0)   a_px0_h = h;
        if (px_a == 10'd639) a_px639_h = h;
        if (py_a == 10'd0)   a_py0++;
      end
      if (t_cnt / 800 == 34 && (px_a != 10'h3FF || py_a != 10'h3FF || rgb_a != 12'h000))
        a_l34_bad++;
      if (fs_s) begin
        s_fs_cnt++;
        if (s_fs_cnt == 1) s_fs_t1 = t_cnt;
        if (s_fs_cnt == 2) s_fs_t2 = t_cnt;
      end
      if (t_cnt < 160 && vs_s == 1'b1) s_vs_act0++;
      if (t_cnt == 40800) s_fc_255 = fc_s;
      if (t_cnt == 40960) begin
        s_fc_wrap = fc_s;
        s_fs_wrap = fs_s;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_hsync"}, hs_a, 1'b0);
    chk({tag, "_a_vsync"}, vs_a, 1'b0);
    chk({tag, "_a_pix_x"}, px_a, 10'h3FF);
    chk({tag, "_a_pix_y"}, py_a, 10'h3FF);
    chk({tag, "_a_rgb"}, rgb_a, 12'h000);
    chk({tag, "_a_frame_start"}, fs_a, 1'b0);
    chk({tag, "_a_frame_cnt"}, fc_a, 8'd0);
    chk({tag, "_s_hsync"}, hs_s, 1'b1);
    chk({tag, "_s_vsync"}, vs_s, 1'b1);
    chk({tag, "_s_pix_x"}, px_s, 10'h3FF);
    chk({tag, "_s_rgb"}, rgb_s, 12'h000);
    chk({tag, "_s_frame_start"}, fs_s, 1'b0);
    chk({tag, "_s_frame_cnt"}, fc_s, 8'd0);
  endtask

  initial begin
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (41220) @(posedge clk);
    phase1 = 1'b0;
    #1;
    chk("a_hsync_low_line0", a_hs_low0, 96);
    chk("a_hsync_high_line0", a_hs_high0, 704);
    chk("a_vsync_low_frame0", a_vs_act0, 1600);
    chk("a_rgb_abc_count_l35", a_abc, 640);
    chk("a_rgb_first_h_l35", a_first, 144);
    chk("a_rgb_last_h_l35", a_last, 783);
    chk("a_pix_x0_h_l35", a_px0_h, 143);
    chk("a_pix_x639_h_l35", a_px639_h, 782);
    chk("a_pix_y0_count_l35", a_py0, 640);
    chk("a_line34_quiet", a_l34_bad, 0);
    chk("s_frame_start_count", s_fs_cnt, 257);
    chk("s_frame_start_first", s_fs_t1, 160);
    chk("s_frame_start_period", s_fs_t2 - s_fs_t1, 160);
    chk("s_vsync_active_frame0", s_vs_act0, 32);
    chk("s_frame_cnt_255", s_fc_255, 255);
    chk("s_frame_cnt_wrap", s_fc_wrap, 0);
    chk("s_frame_start_at_wrap", s_fs_wrap, 1);
    chk("s_frame_cnt_pre_reset", fc_s, 8'd1);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Generates 640x480@60 Hz VGA raster timing on the 25 MHz pixel clock and drives the display pins. It supplies `pix_x`/`pix_y` to the downstream picture generator (status bars plus song-title bitmap), which registers `pix_data` one cycle later. It then gates that returned `pix_data` onto the `rgb` pins during the visible window. It also emits a per-frame strobe and a frame counter for animation and blink logic.

## Interface
Parameters:
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 40, horizontal back porch
- H_LEFT, 8, left border
- H_VALID, 640, visible pixels per line
- H_RIGHT, 8, right border
- H_FRONT, 8, horizontal front porch (H_TOTAL = sum = 800)
- V_SYNC, 2; V_BACK, 25; V_TOP, 8; V_VALID, 480; V_BOTTOM, 8; V_FRONT, 2 (V_TOTAL = 525)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- vga_clk  in  1  pixel clock, 25 MHz
- sys_rst_n  in  1  **one clock; reset is asynchronous and active-low**
- pix_data  in  12  RGB444 from picture generator; registered there, so it answers the pix_x/pix_y of the previous cycle
- pix_x  out  10  column being requested, 0..639; 10'h3FF when not requesting
- pix_y  out  10  row being requested, 0..479; 10'h3FF when not requesting
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- rgb  out  12  pixel to DAC; 12'h000 outside visible window
- frame_start  out  1  one-cycle pulse at start of each frame
- frame_cnt  out  8  frames since reset, wraps

## Operation
- h_cnt: 0..H_TOTAL-1, +1 every cycle, wraps to 0 after 799.
- v_cnt: +1 only on the cycle h_cnt==799. Wraps to 0 when v_cnt==524 and h_cnt==799.
- HS = H_SYNC+H_BACK+H_LEFT = 144; VS = V_SYNC+V_BACK+V_TOP = 35.
- hsync = SYNC_POL while h_cnt < H_SYNC, else ~SYNC_POL. vsync = SYNC_POL while v_cnt < V_SYNC, else ~SYNC_POL. Both are decoded directly from the counters.
- rgb_valid = (HS ≤ h_cnt < HS+640) && (VS ≤ v_cnt < VS+480).
- pix_req = (HS-1 ≤ h_cnt < HS+639) && (VS ≤ v_cnt < VS+480). This window is rgb_valid advanced one cycle to cover the consumer's register stage.
- pix_x = pix_req ? h_cnt-(HS-1) : 10'h3FF. pix_y = pix_req ? v_cnt-VS : 10'h3FF. Both are 10-bit unsigned, with no truncation in range.
- rgb = rgb_valid ? pix_data : 12'h000.
- frame_start and frame_cnt are registered. On the wrap cycle (h_cnt==799 && v_cnt==524), the next edge sets frame_start=1 and increments frame_cnt. frame_start clears on the following edge. frame_cnt wraps 255→0.
- There is no state beyond h_cnt, v_cnt, frame_start and frame_cnt.

## Timing
- Reset values: h_cnt=0, v_cnt=0, frame_start=0, frame_cnt=0.
- Resulting combinational outputs during reset: hsync=SYNC_POL, vsync=SYNC_POL, pix_x=pix_y=10'h3FF, rgb=12'h000.
- Reset asserted mid-line or mid-frame: all state clears immediately, with no partial frame_start. The first edge after release counts h_cnt 0→1.
- Line period is 800 cycles; frame period is 420 000 cycles.
- hsync is active for h_cnt 0..95. vsync is active for the 1600 cycles where v_cnt is 0..1.
- pix_x=0 at h_cnt=143 and pix_x=639 at h_cnt=782. The matching rgb pixel appears one cycle later, at h_cnt=144 and h_cnt=783.
- At line end (h_cnt=799) and frame end, the counter wrap and the v_cnt update occur on the same edge.
- frame_start is high during the cycle where h_cnt=0 and v_cnt=0, one cycle after the wrap. This is the first cycle of vsync.

## Test plan
- Reset held for 10 cycles, then released → during reset: hsync=0, vsync=0, pix_x=3FF, pix_y=3FF, rgb=000, frame_cnt=0. After release, h_cnt=1 on the first edge.
- Run one full line → hsync low for exactly 96 cycles, then high for 704. The line repeats every 800 cycles.
- Drive pix_data=12'hABC constantly; check line v_cnt=35 → pix_x goes 0..639 over h_cnt 143..782. rgb=ABC exactly for h_cnt 144..783 (640 cycles) and 000 elsewhere. pix_y=0 throughout.
- Check lines v_cnt=34 and v_cnt=515 → pix_x/pix_y stay 3FF and rgb stays 000 for the whole line.
- Run 2 full frames → vsync low for 1600 cycles each frame. frame_start pulses exactly 2 times, 420 000 cycles apart, each 1 cycle wide. frame_cnt=2.
- Force frame_cnt to 255, then run one frame → frame_cnt wraps to 0 with frame_start=1. Assert reset at h_cnt=400, v_cnt=200 → all outputs return to reset values asynchronously.
